bi_channel_ctrl: RTL and testbench



---
 rtl/bi_channel_ctrl.sv | 170 +++++++++++++++++
 tb/tb_bi_channel_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bi_channel_ctrl.sv
// ---------------------------------------------------------------------------
// bi_channel_ctrl
//
// Direction controller for one end of a bidirectional inter-router channel.
// The two ends pass a single ownership token back and forth. Only the owner
// drives the link. Every direction change inserts a turnaround gap: this end
// holds its select low for TURN_CYC cycles before the token pulse. The peer
// then needs one more cycle before it can raise its own select.
//
// Parameters
//   HIGH_PRIO  1: this end owns the channel out of reset (peer must use 0)
//   MAX_PKTS   packets the owner may finish while the peer waits (>=1)
//   TURN_CYC   turnaround cycles before the token is passed (>=1)
//
// Ports
//   clk             clock
//   rst             synchronous active-high reset
//   i_local_req     local output has a flit for this channel
//   i_local_tail    qualifies i_local_req: flit is the packet's last
//   i_peer_req      peer wants to transmit (peer's o_req_out)
//   i_token_in      one-cycle pulse: peer hands ownership to this end
//   o_inout_select  this end drives the link (flit sent when & i_local_req)
//   o_req_out       registered i_local_req while not owner, else 0
//   o_token_out     one-cycle pulse passing ownership to the peer
//   o_proto_err     sticky: token arrived while owner or in handoff
// ---------------------------------------------------------------------------
module bi_channel_ctrl #(
  parameter int HIGH_PRIO = 1,
  parameter int MAX_PKTS  = 2,
  parameter int TURN_CYC  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_local_req,
  input  logic i_local_tail,
  input  logic i_peer_req,
  input  logic i_token_in,
  output logic o_inout_select,
  output logic o_req_out,
  output logic o_token_out,
  output logic o_proto_err
);

  localparam int PKT_W  = $clog2(MAX_PKTS + 1);
  localparam int TURN_W = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_ACTIVE,
    HANDOFF,
    NOT_OWN
  } state_t;

  localparam state_t RESET_STATE = (HIGH_PRIO != 0) ? OWN_IDLE : NOT_OWN;

  state_t              r_state, w_state_next;
  logic [PKT_W-1:0]    r_pkt_cnt, w_pkt_cnt_next;
  logic [TURN_W-1:0]   r_turn_cnt, w_turn_cnt_next;
  logic                r_in_pkt, w_in_pkt_next;
  logic                r_sel, w_sel_next;
  logic                r_req, w_req_next;
  logic                r_token, w_token_next;
  logic                r_proto_err, w_proto_err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RESET_STATE;
      r_pkt_cnt   <= '0;
      r_turn_cnt  <= '0;
      r_in_pkt    <= 1'b0;
      r_sel       <= 1'b0;
      r_req       <= 1'b0;
      r_token     <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pkt_cnt   <= w_pkt_cnt_next;
      r_turn_cnt  <= w_turn_cnt_next;
      r_in_pkt    <= w_in_pkt_next;
      r_sel       <= w_sel_next;
      r_req       <= w_req_next;
      r_token     <= w_token_next;
      r_proto_err <= w_proto_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_pkt_cnt_next   = r_pkt_cnt;
    w_turn_cnt_next  = r_turn_cnt;
    w_in_pkt_next    = r_in_pkt;
    w_token_next     = 1'b0;
    // A token is only legal while we do not own the channel; otherwise it is
    // ignored and flagged until reset.
    w_proto_err_next = r_proto_err | (i_token_in & (r_state != NOT_OWN));

    case (r_state)
      OWN_IDLE: begin
        if (i_local_req) begin
          w_state_next   = OWN_ACTIVE;
          w_pkt_cnt_next = '0;
          w_in_pkt_next  = 1'b0;
        end else if (i_peer_req) begin
          w_state_next    = HANDOFF;
          w_turn_cnt_next = '0;
        end
      end

      OWN_ACTIVE: begin
        // Select is high here, so every requested flit is actually sent.
        if (i_local_req) begin
          w_in_pkt_next = ~i_local_tail;
          if (i_local_tail && i_peer_req) begin
            if (int'(r_pkt_cnt) < MAX_PKTS) begin
              w_pkt_cnt_next = r_pkt_cnt + PKT_W'(1);
            end
            // Quota used up: yield straight after this tail. If the quota is
            // not used up but the local side goes quiet, the idle branch
            // below yields on the following cycle.
            if (int'(r_pkt_cnt) + 1 >= MAX_PKTS) begin
              w_state_next    = HANDOFF;
              w_turn_cnt_next = '0;
            end
          end
        end else if (!r_in_pkt) begin
          // Between packets with nothing to send. A bubble inside a packet
          // keeps the direction.
          if (i_peer_req) begin
            w_state_next    = HANDOFF;
            w_turn_cnt_next = '0;
          end else begin
            w_state_next = OWN_IDLE;
          end
        end
      end

      HANDOFF: begin
        // Committed: neither peer_req nor local_req can cancel it.
        if (r_turn_cnt == TURN_W'(TURN_CYC - 1)) begin
          w_state_next    = NOT_OWN;
          w_token_next    = 1'b1;
          w_turn_cnt_next = '0;
        end else begin
          w_turn_cnt_next = r_turn_cnt + TURN_W'(1);
        end
      end

      NOT_OWN: begin
        if (i_token_in) begin
          w_state_next = OWN_IDLE;
        end
      end

      default: begin
        w_state_next = RESET_STATE;
      end
    endcase

    // Outputs are registered from the next-state decode, so they line up
    // with the state they describe and have no input-to-output path.
    w_sel_next = (w_state_next == OWN_ACTIVE);
    w_req_next = (w_state_next == NOT_OWN) & i_local_req;
  end

  assign o_inout_select = r_sel;
  assign o_req_out      = r_req;
  assign o_token_out    = r_token;
  assign o_proto_err    = r_proto_err;

endmodule

// File: tb/tb_bi_channel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bi_channel_ctrl
//
// Two cross-connected ends (A: HIGH_PRIO=1, B: HIGH_PRIO=0). Inputs are
// generated randomly within phases. Each cycle the outputs of both ends are
// compared with a behavioural model of channel ownership. The model tracks
// owner / driving / remaining-gap / packet-quota. Extra token pulses can be
// injected into an end that already owns the channel. Occasional resets
// land at arbitrary points, including mid-handoff.
// ---------------------------------------------------------------------------
module tb_bi_channel_ctrl;

  localparam int MAX  = 2;
  localparam int TURN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lr_a = 1'b0, lt_a = 1'b0, lr_b = 1'b0, lt_b = 1'b0;
  logic inj_a = 1'b0, inj_b = 1'b0;
  logic a_sel, a_req, a_tok, a_err;
  logic b_sel, b_req, b_tok, b_err;
  logic a_tin, b_tin;

  assign a_tin = b_tok | inj_a;
  assign b_tin = a_tok | inj_b;

  always #5 clk = ~clk;

  bi_channel_ctrl #(.HIGH_PRIO(1), .MAX_PKTS(MAX), .TURN_CYC(TURN)) u_a (
    .clk(clk), .rst(rst),
    .i_local_req(lr_a), .i_local_tail(lt_a),
    .i_peer_req(b_req), .i_token_in(a_tin),
    .o_inout_select(a_sel), .o_req_out(a_req),
    .o_token_out(a_tok), .o_proto_err(a_err)
  );

  bi_channel_ctrl #(.HIGH_PRIO(0), .MAX_PKTS(MAX), .TURN_CYC(TURN)) u_b (
    .clk(clk), .rst(rst),
    .i_local_req(lr_b), .i_local_tail(lt_b),
    .i_peer_req(a_req), .i_token_in(b_tin),
    .o_inout_select(b_sel), .o_req_out(b_req),
    .o_token_out(b_tok), .o_proto_err(b_err)
  );

  // Behavioural view of one end: does it hold the token, is it driving,
  // how many turnaround cycles remain, and how many packets it has finished
  // while the peer was waiting.
  typedef struct packed {
    bit owner;
    bit active;
    int gap;
    int pkts;
    bit in_pkt;
    bit err;
    bit req;
    bit tok;
  } mdl_t;

  mdl_t ma, mb;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int a_idx = 0, a_len = 3, b_idx = 0, b_len = 3;
  int fix_len_a = 0, fix_len_b = 0;

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s cycle %0d: got %0b expected %0b", tag, cyc, got, exp);
    end
  endtask

  function automatic mdl_t mdl_reset(input bit hp);
    mdl_t m;
    m = '0;
    m.owner = hp;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input bit lr, input bit lt,
                                    input bit pr, input bit ti);
    mdl_t n;
    bit yield;
    n = s;
    n.tok = 1'b0;
    yield = 1'b0;
    if (ti && (s.owner || s.gap > 0)) n.err = 1'b1;
    if (s.gap > 0) begin
      n.gap = s.gap - 1;
      if (n.gap == 0) n.tok = 1'b1;
    end else if (!s.owner) begin
      if (ti) n.owner = 1'b1;
    end else if (!s.active) begin
      if (lr) begin
        n.active = 1'b1;
        n.pkts   = 0;
        n.in_pkt = 1'b0;
      end else if (pr) begin
        yield = 1'b1;
      end
    end else begin
      if (lr) begin
        n.in_pkt = !lt;
        if (lt && pr) begin
          n.pkts = (s.pkts + 1 > MAX) ? MAX : s.pkts + 1;
          if (s.pkts + 1 >= MAX) yield = 1'b1;
        end
      end else if (!s.in_pkt) begin
        n.active = 1'b0;
        if (pr) yield = 1'b1;
      end
    end
    if (yield) begin
      n.owner  = 1'b0;
      n.active = 1'b0;
      n.gap    = TURN;
    end
    n.req = (!n.owner && n.gap == 0) ? lr : 1'b0;
    return n;
  endfunction

  function automatic int next_len(input int fixed);
    return (fixed != 0) ? fixed : int'($urandom_range(5, 1));
  endfunction

  task automatic tick();
    mdl_t na, nb;
    bit sa, sb;
    sa = ma.active && lr_a;
    sb = mb.active && lr_b;
    if (rst) begin
      na = mdl_reset(1'b1);
      nb = mdl_reset(1'b0);
    end else begin
      na = mdl_step(ma, lr_a, lt_a, mb.req, mb.tok | inj_a);
      nb = mdl_step(mb, lr_b, lt_b, ma.req, ma.tok | inj_b);
    end
    @(posedge clk);
    #1;
    cyc++;
    ma = na;
    mb = nb;
    check("a_sel", a_sel, ma.active);
    check("a_req", a_req, ma.req);
    check("a_tok", a_tok, ma.tok);
    check("a_err", a_err, ma.err);
    check("b_sel", b_sel, mb.active);
    check("b_req", b_req, mb.req);
    check("b_tok", b_tok, mb.tok);
    check("b_err", b_err, mb.err);
    check("excl",  a_sel & b_sel, 1'b0);
    if (ma.tok) $display("[TB] cycle %0d: token A->B", cyc);
    if (mb.tok) $display("[TB] cycle %0d: token B->A", cyc);
    if (rst) begin
      a_idx = 0;
      b_idx = 0;
    end else begin
      if (sa) begin
        if (lt_a) begin a_idx = 0; a_len = next_len(fix_len_a); end
        else a_idx++;
      end
      if (sb) begin
        if (lt_b) begin b_idx = 0; b_len = next_len(fix_len_b); end
        else b_idx++;
      end
    end
  endtask

  // pa/pb: percent chance of local_req; inj_pm/rst_pm: per-mille chances.
  task automatic run(input int n, input int pa, input int pb,
                     input int inj_pm, input int rst_pm);
    for (int i = 0; i < n; i++) begin
      rst   = ($urandom_range(999) < rst_pm);
      lr_a  = ($urandom_range(99) < pa);
      lt_a  = (a_idx == a_len - 1);
      lr_b  = ($urandom_range(99) < pb);
      lt_b  = (b_idx == b_len - 1);
      inj_a = !rst && (ma.owner || ma.gap > 0) && ($urandom_range(999) < inj_pm);
      inj_b = !rst && (mb.owner || mb.gap > 0) && ($urandom_range(999) < inj_pm);
      tick();
    end
  endtask

  initial begin
    ma = mdl_reset(1'b1);
    mb = mdl_reset(1'b0);
    // Reset for two cycles, then settle.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    run(3, 0, 0, 0, 0);
    // Owner sends one 3-flit packet with no peer request.
    fix_len_a = 3; fix_len_b = 3; a_len = 3; b_len = 3;
    run(4, 100, 0, 0, 0);
    run(4, 0, 0, 0, 0);
    // Fair yield: both sides stream 4-flit packets.
    fix_len_a = 4; fix_len_b = 4; a_len = 4; b_len = 4; a_idx = 0; b_idx = 0;
    run(80, 100, 100, 0, 0);
    // Bursty traffic with bubbles and random packet lengths.
    fix_len_a = 0; fix_len_b = 0;
    run(1500, 70, 60, 0, 0);
    // Add stray tokens and occasional resets.
    run(2500, 65, 65, 10, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
